// File: rtl/alu_pkg.sv
// Shared constants for the nibble-serial ALU sequencer and the 4-bit ALU slice:
// opcode encoding, sequencer state encoding and the slice width.
package alu_pkg;

    localparam int NIB_W = 4;

    localparam logic [2:0] OP_PASSA = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_NOTA  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_4b.sv
// Combinational 4-bit ALU slice. Subtract is A + ~B + Cin so that Cout means
// "no borrow"; logic ops and the reserved code drive Cout low.
module alu_4b
    import alu_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic [2:0]       s,
    input  logic             cin,
    output logic [NIB_W-1:0] f,
    output logic             cout
);

    logic [NIB_W:0] sum;

    always_comb begin
        sum  = '0;
        f    = '0;
        cout = 1'b0;
        case (s)
            OP_PASSA: f = a;
            OP_ADD: begin
                sum  = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
                f    = sum[NIB_W-1:0];
                cout = sum[NIB_W];
            end
            OP_SUB: begin
                sum  = {1'b0, a} + {1'b0, ~b} + {{NIB_W{1'b0}}, cin};
                f    = sum[NIB_W-1:0];
                cout = sum[NIB_W];
            end
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_XOR:  f = a ^ b;
            OP_NOTA: f = ~a;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer around alu_4b: runs WIDTH-bit ops one nibble per cycle
// with carry chaining. Define ALU_SEQ_ACC_EN to add the result accumulator.
module alu_nibble_seq
    import alu_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [4*NIBBLES-1:0]   cmd_a,
    input  logic [4*NIBBLES-1:0]   cmd_b,
    input  logic                   cmd_cin,
    input  logic                   cmd_use_acc,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   res_data,
    output logic                   res_c,
    output logic                   res_z,
    output logic                   res_n,
    output logic                   res_v,
    output logic                   res_err,
    output logic [1:0]             state_dbg
);

    localparam int WIDTH = NIB_W * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a result stays frozen in DONE until res_ready takes it.
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             carry_q;

    logic             accept;
    logic             last_nib;
    logic             arith;
    logic             rsvd;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] res_next;
    logic [NIB_W-1:0] alu_a;
    logic [NIB_W-1:0] alu_b;
    logic [NIB_W-1:0] alu_f;
    logic             alu_cin;
    logic             alu_cout;
    logic             v_next;

    assign cmd_ready = (state == ST_IDLE) || ((state == ST_DONE) && res_ready);
    assign accept    = cmd_valid && cmd_ready;
    assign res_valid = (state == ST_DONE);
    assign state_dbg = state;
    assign last_nib  = (cnt == LAST_CNT);
    assign arith     = is_arith(op_q);
    assign rsvd      = (op_q == OP_RSVD);
    assign alu_a     = a_q[int'(cnt) * NIB_W +: NIB_W];
    assign alu_b     = b_q[int'(cnt) * NIB_W +: NIB_W];

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (res_valid && res_ready) begin
            acc_q <= res_data;
        end
    end

    assign a_src = cmd_use_acc ? acc_q : cmd_a;
`else
    logic unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign a_src          = cmd_a;
`endif

    // Only the first nibble sees the command carry; later ones chain Cout.
    always_comb begin
        alu_cin = 1'b0;
        if (cnt == '0) begin
            if (op_q == OP_ADD) begin
                alu_cin = cin_q;
            end else if (op_q == OP_SUB) begin
                alu_cin = 1'b1;
            end
        end else if (arith) begin
            alu_cin = carry_q;
        end
    end

    alu_4b u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .s    (op_q),
        .cin  (alu_cin),
        .f    (alu_f),
        .cout (alu_cout)
    );

    always_comb begin
        res_next = res_data;
        res_next[int'(cnt) * NIB_W +: NIB_W] = rsvd ? '0 : alu_f;
    end

    always_comb begin
        v_next = 1'b0;
        if (op_q == OP_ADD) begin
            v_next = (a_q[WIDTH-1] ^ res_next[WIDTH-1]) & (b_q[WIDTH-1] ^ res_next[WIDTH-1]);
        end else if (op_q == OP_SUB) begin
            v_next = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ res_next[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= OP_PASSA;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            res_data <= '0;
            res_c    <= 1'b0;
            res_z    <= 1'b0;
            res_n    <= 1'b0;
            res_v    <= 1'b0;
            res_err  <= 1'b0;
        end else if (accept) begin
            op_q  <= cmd_op;
            a_q   <= a_src;
            b_q   <= cmd_b;
            cin_q <= cmd_cin;
            cnt   <= '0;
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    res_data <= res_next;
                    carry_q  <= alu_cout;
                    if (last_nib) begin
                        cnt     <= '0;
                        state   <= ST_DONE;
                        res_c   <= arith & alu_cout;
                        res_z   <= ~rsvd & (res_next == '0);
                        res_n   <= res_next[WIDTH-1];
                        res_v   <= v_next;
                        res_err <= rsvd;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq (NIBBLES=2): directed and random commands, results
// checked by a scoreboard against a whole-word arithmetic model.
module tb_alu_nibble_seq;

    localparam int NIBBLES = 2;
    localparam int W       = 4 * NIBBLES;
    localparam int EW      = W + 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_cin;
    logic         cmd_use_acc;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_c;
    logic         res_z;
    logic         res_n;
    logic         res_v;
    logic         res_err;
    logic [1:0]   state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [EW-1:0] exp_q[$];
    int            acc_cyc_q[$];
    logic [W-1:0]  model_acc = '0;
    bit            first_seen = 0;
    bit            rand_ready_en = 0;

    alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_cin     (cmd_cin),
        .cmd_use_acc (cmd_use_acc),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_c       (res_c),
        .res_z       (res_z),
        .res_n       (res_n),
        .res_v       (res_v),
        .res_err     (res_err),
        .state_dbg   (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // random consumer backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (rand_ready_en) res_ready = ($urandom_range(0, 3) != 0);
    end

    // packed as {err, v, n, z, c, data}
    function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        logic [W:0]   wide;
        logic [W-1:0] d;
        logic         c, v, err;
        d = '0; c = 1'b0; v = 1'b0; err = 1'b0;
        case (op)
            3'd0: d = a;
            3'd1: begin
                wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                d = wide[W-1:0];
                c = wide[W];
                v = (a[W-1] == b[W-1]) && (d[W-1] != a[W-1]);
            end
            3'd2: begin
                d = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
            end
            3'd3: d = a & b;
            3'd4: d = a | b;
            3'd5: d = a ^ b;
            3'd6: d = ~a;
            default: err = 1'b1;
        endcase
        return {err, v, d[W-1], (d == '0) && !err, c, d};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // driver: present a command, wait (bounded) for acceptance, then scramble inputs
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic use_acc, input bit push);
        int waited = 0;
        logic [W-1:0] a_eff;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_use_acc = use_acc;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, required 1", waited);
            cmd_valid = 1'b0;
            return;
        end
        a_eff = a;
`ifdef ALU_SEQ_ACC_EN
        if (use_acc) a_eff = model_acc;
`endif
        if (push) begin
            exp_q.push_back(model(op, a_eff, b, cin));
            acc_cyc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_a     = W'($urandom);
        cmd_b     = W'($urandom);
        cmd_cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || res_valid) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0 || res_valid) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    initial begin : monitor
        logic [EW-1:0] got;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                first_seen = 0;
            end else if (res_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got data=%0h, required no res_valid", res_data);
                end else begin
                    got = {res_err, res_v, res_n, res_z, res_c, res_data};
                    check("result", 32'(got), 32'(exp_q[0]));
                    if (!first_seen) begin
                        first_seen = 1;
                        check("latency", 32'(cyc - acc_cyc_q[0]), NIBBLES);
                        void'(acc_cyc_q.pop_front());
                    end
                    if (!res_ready) begin
                        check("cmd_ready_stall", 32'(cmd_ready), 0);
                    end else begin
                        model_acc = exp_q[0][W-1:0];
                        void'(exp_q.pop_front());
                        first_seen = 0;
                    end
                end
            end
        end
    end

    logic [2:0]   d_op[12] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd7, 3'd1, 3'd1};
    logic [W-1:0] d_a[12]  = '{8'hAA, 8'h07, 8'h03, 8'h80, 8'hA6, 8'hA6, 8'hA6, 8'hA6, 8'hA6, 8'hA6, 8'hFF, 8'h7F};
    logic [W-1:0] d_b[12]  = '{8'h66, 8'h03, 8'h07, 8'h01, 8'h6C, 8'h6C, 8'h6C, 8'h6C, 8'h6C, 8'h6C, 8'h00, 8'h00};
    logic         d_c[12]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin : main
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_cin = 1'b0; cmd_use_acc = 1'b0; res_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 32'({res_valid, res_err, res_v, res_n, res_z, res_c, res_data}), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // reset in the middle of a run discards the command
        send(3'd1, 8'h12, 8'h34, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_rst_outputs", 32'({res_valid, res_err, res_v, res_n, res_z, res_c, res_data}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrun_cmd_ready", 32'(cmd_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrun_no_valid", 32'(res_valid), 0);
        end
        @(posedge clk); #1;

        // directed ops, back-to-back with res_ready high
        for (int i = 0; i < 12; i++) send(d_op[i], d_a[i], d_b[i], d_c[i], 1'b0, 1);
        drain();

        // backpressure, then same-edge accept on release
        res_ready = 1'b0;
        send(3'd1, 8'h3C, 8'h55, 1'b1, 1'b0, 1);
        fork
            send(3'd2, 8'h10, 8'h20, 1'b0, 1'b0, 1);
            begin
                repeat (NIBBLES + 5) @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        drain();

        // accumulator chain (A = previous result only when the feature is built in)
        send(3'd1, 8'h05, 8'h03, 1'b0, 1'b0, 1);
        drain();
        send(3'd1, 8'h33, 8'h10, 1'b0, 1'b1, 1);
        drain();

        // random traffic with random consumer stalls
        rand_ready_en = 1;
        for (int i = 0; i < 60; i++) begin
            logic ua;
`ifdef ALU_SEQ_ACC_EN
            ua = 1'b0;
`else
            ua = 1'($urandom_range(0, 1));
`endif
            send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ua, 1);
        end
        rand_ready_en = 0;
        @(posedge clk); #2;
        res_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-cycle operand sequencer that sits directly upstream of alu_4b and drives its A/B/S/Cin inputs one nibble per cycle.
- Captures F/Cout into a result register, chaining carry across nibbles, so the 4-bit ALU executes WIDTH-bit operations.
- Valid/ready on both command and result sides; produces Z/N/C/V flags for downstream consumers.

Parameters:
- NIBBLES, 2, operand width in nibbles; WIDTH = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept command
- cmd_op  input  3  alu_4b select encoding: 000 passA, 001 add, 010 sub, 011 and, 100 or, 101 xor, 110 notA, 111 reserved
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- cmd_cin  input  1  carry-in for add; ignored for all other ops
- cmd_use_acc  input  1  use accumulator as A; see Optional Feature
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  WIDTH  result
- res_c  output  1  carry out (add) / no-borrow (sub); 0 for logic ops
- res_z  output  1  res_data == 0
- res_n  output  1  res_data[WIDTH-1]
- res_v  output  1  signed overflow (add/sub only; else 0)
- res_err  output  1  reserved opcode; res_data = 0, all flags 0

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, rst_n low): state IDLE, nibble counter 0, res_valid 0, res_data 0, all flags 0, accumulator 0.
  - Reset mid-RUN discards the command; no partial result is ever presented.
- cmd_ready = (state==IDLE) | (state==DONE & res_ready).
  - Command accepted on a rising edge with cmd_valid & cmd_ready: latch op, A, B, cin; counter = 0; go RUN.
- RUN: drive alu_4b with nibble[cnt] of A and B and S = op.
  - Cin for nibble 0: add = cmd_cin, sub = 1, logic = 0.
  - Cin for nibble i>0: registered Cout of nibble i-1 for add/sub, 0 otherwise.
  - F is written into res_data nibble cnt each edge.
  - After nibble NIBBLES-1, go DONE. Counter wraps to 0, never exceeds NIBBLES-1.
- Latency: res_valid rises NIBBLES edges after the accepting edge. Throughput is one op per NIBBLES+1 cycles with res_ready held high.
- DONE: res_valid=1; res_data and flags stable while res_valid & ~res_ready.
  - On res_ready, go IDLE, or RUN if a new command is accepted the same edge (back-to-back).
- Flags are computed on entry to DONE from the full WIDTH-bit result.
  - res_c = final-nibble Cout for add/sub.
  - res_v, add: (A^F)&(B^F) at msb.
  - res_v, sub: (A^B)&(A^F) at msb.
- Reserved op 111: no ALU passes; go DONE after NIBBLES cycles as normal with res_err=1.
- Operands and op are held internally; changes to cmd_* after acceptance have no effect.

Optional Feature:
- Macro ALU_SEQ_ACC_EN.
- Defined: a WIDTH-bit accumulator loads res_data on every completed result handshake. A command with cmd_use_acc=1 uses the accumulator as A instead of cmd_a. Accumulator resets to 0.
- Undefined: no accumulator storage; cmd_use_acc is ignored and A is always cmd_a.

Decomposition:
- Shared package alu_pkg:
  - op encoding constants OP_PASSA..OP_NOTA, OP_RSVD
  - state enum
  - nibble width constant 4
- Sub-module: existing alu_4b instantiated once, unmodified. No other sub-modules.

Test Plan (NIBBLES=2):
- Reset mid-RUN: accept add, assert rst_n low on the following cycle -> all outputs 0, cmd_ready=1 after release, no res_valid.
- Add: op=001, A=0xAA, B=0x66, cin=0 -> res_data=0x10, C=1, Z=0, N=0, V=0, res_valid exactly 2 edges after acceptance.
- Sub: op=010, A=0x07, B=0x03 -> 0x04, C=1. Then A=0x03, B=0x07 -> 0xFC, C=0, N=1. Then A=0x80, B=0x01 -> 0x7F, V=1.
- Logic: AND 0xA6&0x6C=0x24; OR=0xEE; XOR=0xCA; NOT A=0x59; passA=0xA6 -> C=V=0. Reserved 111 -> res_err=1, data 0x00, Z=0.
- Backpressure: hold res_ready=0 for 5 cycles -> res_data and flags stable, cmd_ready=0. Raise res_ready with cmd_valid high -> same-edge accept, next result 2 edges later.
- ALU_SEQ_ACC_EN defined: add 0x05+0x03 -> 0x08. Then add use_acc=1, B=0x10 -> 0x18. With macro undefined, the same sequence gives cmd_a+0x10.
